xpb_lut_gen: RTL and testbench

- Run-time generator and server for the reduction-multiple table used by the modular squaring datapath.
- On start, fills an internal table with entry[k] = (k * base) mod modulus for k = 0 .. 2^IDX_BITS-1, computing one entry per clock by iterative modular addition.
- It then serves registered lookups indexed by one IDX_BITS chunk, so one module covers any modulus and chunk width without a hard-coded constant table.

---
 rtl/xpb_lut_gen.sv | 151 +++++++++++++++
 tb/tb_xpb_lut_gen.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xpb_lut_gen.sv
// Run-time generator and server for the k*base mod modulus reduction-multiple table.
// Optional macro XPB_LUT_DUAL_READ_EN adds a second independent lookup port.
module xpb_lut_gen #(
  parameter int WORD_BITS = 1024,
  parameter int IDX_BITS  = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WORD_BITS-1:0] modulus,
  input  logic [WORD_BITS-1:0] base,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 ready,
  input  logic                 rd_en,
  input  logic [IDX_BITS-1:0]  rd_idx,
  output logic                 rd_valid,
  output logic [WORD_BITS-1:0] rd_data
`ifdef XPB_LUT_DUAL_READ_EN
  ,
  input  logic                 rd2_en,
  input  logic [IDX_BITS-1:0]  rd2_idx,
  output logic                 rd2_valid,
  output logic [WORD_BITS-1:0] rd2_data
`endif
);

  localparam int                DEPTH  = 1 << IDX_BITS;
  localparam logic [IDX_BITS:0] K_LAST = (IDX_BITS + 1)'(DEPTH - 1);
  localparam logic [IDX_BITS:0] K_ONE  = (IDX_BITS + 1)'(1);

  typedef enum logic [1:0] {IDLE, CHECK, GEN, READY} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [WORD_BITS-1:0]   m_r;
  logic [WORD_BITS-1:0]   c_r;
  logic [WORD_BITS-1:0]   acc;
  logic [IDX_BITS:0]      k;
  logic                   done_r;
  logic                   accept;
  logic                   c_ge_m;
  logic [WORD_BITS:0]     sum;
  logic [WORD_BITS-1:0]   acc_nxt;
  logic [WORD_BITS-1:0]   table_mem [DEPTH];
  logic                   s1_valid;
  logic [IDX_BITS-1:0]    s1_idx;

  assign accept = start && ((state == IDLE) || (state == READY));
  assign c_ge_m = (c_r >= m_r);
  // One extra bit keeps the carry of acc + C when the modulus fills the word.
  assign sum     = {1'b0, acc} + {1'b0, c_r};
  assign acc_nxt = (sum >= {1'b0, m_r}) ? WORD_BITS'(sum - {1'b0, m_r}) : sum[WORD_BITS-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CHECK;
      CHECK:   state_nxt = c_ge_m ? IDLE : GEN;
      GEN:     if (k == K_LAST) state_nxt = READY;
      READY:   if (accept) state_nxt = CHECK;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    err   = 1'b0;
    ready = 1'b0;
    done  = done_r;
    case (state)
      CHECK:   begin
        busy = !c_ge_m;
        err  = c_ge_m;
      end
      GEN:     busy  = 1'b1;
      READY:   ready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_r    <= '0;
      c_r    <= '0;
      acc    <= '0;
      k      <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (accept) begin
        m_r <= modulus;
        c_r <= base;
      end
      if (state == CHECK && !c_ge_m) begin
        acc <= c_r;
        k   <= K_ONE;
      end else if (state == GEN) begin
        acc <= acc_nxt;
        k   <= k + K_ONE;
        if (k == K_LAST) done_r <= 1'b1;
      end
    end
  end

  // Table contents are don't-care after reset, so the array has no reset.
  always_ff @(posedge clk) begin
    if (state == CHECK && !c_ge_m) table_mem[0] <= '0;
    else if (state == GEN)         table_mem[k[IDX_BITS-1:0]] <= acc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      s1_valid <= rd_en && ready;
      if (rd_en && ready) s1_idx <= rd_idx;
      rd_valid <= s1_valid;
      if (s1_valid) rd_data <= table_mem[s1_idx];
    end
  end

`ifdef XPB_LUT_DUAL_READ_EN
  logic                s2_valid;
  logic [IDX_BITS-1:0] s2_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid  <= 1'b0;
      s2_idx    <= '0;
      rd2_valid <= 1'b0;
      rd2_data  <= '0;
    end else begin
      s2_valid <= rd2_en && ready;
      if (rd2_en && ready) s2_idx <= rd2_idx;
      rd2_valid <= s2_valid;
      if (s2_valid) rd2_data <= table_mem[s2_idx];
    end
  end
`endif

endmodule

// File: tb/tb_xpb_lut_gen.sv
// Bench for xpb_lut_gen: a small (8-bit, 8-entry) instance and a default-size instance,
// checked against a k*C mod M reference model.
module tb_xpb_lut_gen;
  localparam int SW = 8;
  localparam int SI = 3;
  localparam int BW = 1024;
  localparam int BI = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          s_start = 1'b0, s_rd_en = 1'b0;
  logic [SW-1:0] s_mod = '0, s_base = '0;
  logic [SI-1:0] s_rd_idx = '0;
  logic          s_busy, s_done, s_err, s_ready, s_rd_valid;
  logic [SW-1:0] s_rd_data;

  logic          b_start = 1'b0, b_rd_en = 1'b0;
  logic [BW-1:0] b_mod = '0, b_base = '0;
  logic [BI-1:0] b_rd_idx = '0;
  logic          b_busy, b_done, b_err, b_ready, b_rd_valid;
  logic [BW-1:0] b_rd_data;

`ifdef XPB_LUT_DUAL_READ_EN
  logic          s_rd2_en = 1'b0;
  logic [SI-1:0] s_rd2_idx = '0;
  logic          s_rd2_valid;
  logic [SW-1:0] s_rd2_data;
  logic          b_rd2_en = 1'b0;
  logic [BI-1:0] b_rd2_idx = '0;
  logic          b_rd2_valid;
  logic [BW-1:0] b_rd2_data;
`endif

  xpb_lut_gen #(.WORD_BITS(SW), .IDX_BITS(SI)) u_small (
    .clk(clk), .reset(rst), .start(s_start), .modulus(s_mod), .base(s_base),
    .busy(s_busy), .done(s_done), .err(s_err), .ready(s_ready),
    .rd_en(s_rd_en), .rd_idx(s_rd_idx), .rd_valid(s_rd_valid), .rd_data(s_rd_data)
`ifdef XPB_LUT_DUAL_READ_EN
    , .rd2_en(s_rd2_en), .rd2_idx(s_rd2_idx), .rd2_valid(s_rd2_valid), .rd2_data(s_rd2_data)
`endif
  );

  xpb_lut_gen u_big (
    .clk(clk), .reset(rst), .start(b_start), .modulus(b_mod), .base(b_base),
    .busy(b_busy), .done(b_done), .err(b_err), .ready(b_ready),
    .rd_en(b_rd_en), .rd_idx(b_rd_idx), .rd_valid(b_rd_valid), .rd_data(b_rd_data)
`ifdef XPB_LUT_DUAL_READ_EN
    , .rd2_en(b_rd2_en), .rd2_idx(b_rd2_idx), .rd2_valid(b_rd2_valid), .rd2_data(b_rd2_data)
`endif
  );

  int total = 0;
  int bad   = 0;

  logic [SW-1:0] s_tab [8];
  bit            s_valid_tab = 1'b0;
  logic [BW-1:0] b_tab [32];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Starts a build on the small instance and checks the flag timeline for 10 cycles.
  task automatic build_small(input logic [SW-1:0] m, input logic [SW-1:0] c, input bit probe);
    bit            ok;
    bit            eb, ed, ee, er;
    logic [SW-1:0] old4;
    ok   = (c < m);
    old4 = s_tab[4];
    s_mod = m; s_base = c; s_start = 1'b1;
    if (probe) begin s_rd_en = 1'b1; s_rd_idx = 3'd4; end
    tick;
    s_start = 1'b0; s_rd_en = 1'b0;
    s_valid_tab = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      eb = ok && (i <= 8);
      ed = ok && (i == 9);
      ee = !ok && (i == 1);
      er = ok && (i >= 9);
      total++;
      if ({s_busy, s_done, s_err, s_ready} !== {eb, ed, ee, er}) begin
        bad++;
        $display("FAIL gen_flags m=%0d c=%0d cyc=+%0d busy/done/err/ready got=%b expected=%b",
                 m, c, i, {s_busy, s_done, s_err, s_ready}, {eb, ed, ee, er});
      end
      if (probe && i == 2) begin
        total++;
        if (s_rd_valid !== 1'b1 || s_rd_data !== old4) begin
          bad++;
          $display("FAIL inflight_old got v=%b d=%0d expected v=1 d=%0d", s_rd_valid, s_rd_data, old4);
        end
      end
      tick;
    end
    if (ok) begin
      for (int k = 0; k < 8; k++) s_tab[k] = SW'((k * int'(c)) % int'(m));
      s_valid_tab = 1'b1;
    end
  endtask

  task automatic read_small(input int n, input bit rnd);
    bit            iss_v [40];
    int            iss_i [40];
    bit            ev;
    bit            any;
    logic [SW-1:0] last_d;
    any = 1'b0; last_d = '0;
    for (int cyc = 0; cyc < n + 2; cyc++) begin
      if (cyc >= 2) begin
        ev = iss_v[cyc-2] && s_valid_tab;
        total++;
        if (s_rd_valid !== ev) begin
          bad++;
          $display("FAIL rd_valid cyc=%0d got=%b expected=%b", cyc, s_rd_valid, ev);
        end
        if (ev) begin
          total++;
          if (s_rd_data !== s_tab[iss_i[cyc-2]]) begin
            bad++;
            $display("FAIL rd_data idx=%0d got=%0d expected=%0d", iss_i[cyc-2], s_rd_data, s_tab[iss_i[cyc-2]]);
          end
          last_d = s_tab[iss_i[cyc-2]];
          any = 1'b1;
        end else if (any) begin
          total++;
          if (s_rd_data !== last_d) begin
            bad++;
            $display("FAIL rd_hold got=%0d expected=%0d", s_rd_data, last_d);
          end
        end
      end
      if (cyc < n) begin
        iss_v[cyc] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        iss_i[cyc] = rnd ? int'($urandom_range(0, 7)) : (cyc % 8);
        s_rd_en  = iss_v[cyc];
        s_rd_idx = SI'(iss_i[cyc]);
      end else begin
        s_rd_en = 1'b0;
      end
      tick;
    end
    if (any) begin
      total++;
      if (s_rd_valid !== 1'b0 || s_rd_data !== last_d) begin
        bad++;
        $display("FAIL rd_idle_hold got v=%b d=%0d expected v=0 d=%0d", s_rd_valid, s_rd_data, last_d);
      end
    end
  endtask

  task automatic build_big(input logic [BW-1:0] m, input logic [BW-1:0] c);
    bit            eb, ed, er;
    logic [BW+7:0] p;
    b_mod = m; b_base = c; b_start = 1'b1;
    tick;
    b_start = 1'b0;
    for (int i = 1; i <= 35; i++) begin
      eb = (i <= 32);
      ed = (i == 33);
      er = (i >= 33);
      total++;
      if ({b_busy, b_done, b_err, b_ready} !== {eb, ed, 1'b0, er}) begin
        bad++;
        $display("FAIL big_flags cyc=+%0d busy/done/err/ready got=%b expected=%b",
                 i, {b_busy, b_done, b_err, b_ready}, {eb, ed, 1'b0, er});
      end
      tick;
    end
    for (int k = 0; k < 32; k++) begin
      p = (BW + 8)'(k) * {8'b0, c};
      b_tab[k] = BW'(p % {8'b0, m});
    end
  endtask

  task automatic read_big(input int n);
    int iss_i [40];
    for (int cyc = 0; cyc < n + 2; cyc++) begin
      if (cyc >= 2) begin
        total++;
        if (b_rd_valid !== 1'b1 || b_rd_data !== b_tab[iss_i[cyc-2]]) begin
          bad++;
          $display("FAIL big_rd idx=%0d v=%b got=%h expected=%h", iss_i[cyc-2], b_rd_valid, b_rd_data, b_tab[iss_i[cyc-2]]);
        end
      end
      if (cyc < n) begin
        iss_i[cyc] = (cyc == 0) ? 31 : (cyc == 1) ? 0 : (cyc == 2) ? 1 : int'($urandom_range(0, 31));
        b_rd_en  = 1'b1;
        b_rd_idx = BI'(iss_i[cyc]);
      end else begin
        b_rd_en = 1'b0;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #5;
    total++;
    if ({s_busy, s_done, s_err, s_ready, s_rd_valid, b_busy, b_done, b_err, b_ready, b_rd_valid} !== 10'b0
        || s_rd_data !== '0 || b_rd_data !== '0) begin
      bad++;
      $display("FAIL reset_outputs got flags=%b small_data=%0d expected all zero",
               {s_busy, s_done, s_err, s_ready, s_rd_valid, b_busy, b_done, b_err, b_ready, b_rd_valid}, s_rd_data);
    end
    #6 rst = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    build_small(8'd13, 8'd5, 1'b0);
    read_small(8, 1'b0);
    read_small(16, 1'b1);
  endtask

  task automatic test_err;
    build_small(8'd13, 8'd13, 1'b0);
    read_small(4, 1'b0);
    build_small(8'd0, 8'd0, 1'b0);
    read_small(3, 1'b0);
    build_small(8'd7, 8'd0, 1'b0);
    read_small(8, 1'b0);
  endtask

  task automatic test_restart;
    build_small(8'd13, 8'd5, 1'b0);
    build_small(8'd11, 8'd3, 1'b1);
    read_small(8, 1'b0);
  endtask

  task automatic test_reset_mid;
    build_small(8'd13, 8'd5, 1'b0);
    s_rd_en = 1'b1; s_rd_idx = 3'd2;
    tick;
    s_rd_en = 1'b0;
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    tick;
    s_valid_tab = 1'b0;
    total++;
    if (s_rd_valid !== 1'b0 || s_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_flush got v=%b ready=%b expected v=0 ready=0", s_rd_valid, s_ready);
    end
    s_mod = 8'd13; s_base = 8'd5; s_start = 1'b1;
    tick;
    s_start = 1'b0;
    repeat (4) tick;
    total++;
    if (s_busy !== 1'b1) begin
      bad++;
      $display("FAIL gen_busy_before_reset got=%b expected=1", s_busy);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({s_busy, s_ready, s_rd_valid, s_done} !== 4'b0) begin
      bad++;
      $display("FAIL reset_mid got busy/ready/valid/done=%b expected=0000", {s_busy, s_ready, s_rd_valid, s_done});
    end
    #1 rst = 1'b0;
    tick;
    build_small(8'd13, 8'd5, 1'b0);
    read_small(8, 1'b0);
  endtask

  task automatic test_random;
    logic [SW-1:0] m, c;
    for (int it = 0; it < 8; it++) begin
      m = SW'($urandom_range(0, 255));
      if (it % 3 == 2 || m == 0) c = SW'($urandom_range(int'(m), 255));
      else                       c = SW'($urandom_range(0, int'(m) - 1));
      build_small(m, c, 1'b0);
      read_small(12, 1'b1);
    end
  endtask

  task automatic test_big;
    logic [BW-1:0] m, c;
    m = '1;
    c = m - 1'b1;
    build_big(m, c);
    read_big(6);
    total++;
    if (b_tab[31] !== ({BW{1'b1}} - BW'(31))) begin
      bad++;
      $display("FAIL big_model_entry31 got=%h", b_tab[31]);
    end
    for (int w = 0; w < BW / 32; w++) m[w*32 +: 32] = $urandom;
    m[BW-1] = 1'b1;
    for (int w = 0; w < BW / 32; w++) c[w*32 +: 32] = $urandom;
    c[BW-1] = 1'b0;
    build_big(m, c);
    read_big(10);
  endtask

  task automatic test_dual;
`ifdef XPB_LUT_DUAL_READ_EN
    build_small(8'd13, 8'd5, 1'b0);
    s_rd_en = 1'b1; s_rd_idx = 3'd3; s_rd2_en = 1'b1; s_rd2_idx = 3'd5;
    tick;
    s_rd_idx = 3'd6; s_rd2_idx = 3'd6;
    tick;
    s_rd_en = 1'b0; s_rd2_en = 1'b0;
    total++;
    if (s_rd_valid !== 1'b1 || s_rd2_valid !== 1'b1 || s_rd_data !== s_tab[3] || s_rd2_data !== s_tab[5]) begin
      bad++;
      $display("FAIL dual_read got d1=%0d d2=%0d expected d1=%0d d2=%0d", s_rd_data, s_rd2_data, s_tab[3], s_tab[5]);
    end
    tick;
    total++;
    if (s_rd_data !== s_tab[6] || s_rd2_data !== s_tab[6]) begin
      bad++;
      $display("FAIL dual_same_idx got d1=%0d d2=%0d expected=%0d", s_rd_data, s_rd2_data, s_tab[6]);
    end
    tick;
`endif
  endtask

  initial begin
    #1;
    test_reset;
    test_basic;
    test_err;
    test_restart;
    test_reset_mid;
    test_random;
    test_big;
    test_dual;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
